// File: rtl/execute_pkg.sv
// Shared execute-stage types: ALU opcodes, M-extension funct3 codes,
// decode/hazard structs and the divider state encoding.
package execute_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } AluOp;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef struct packed {
        logic        enable;
        logic [31:0] pc;
        logic [2:0]  funct3;
        logic        muldiv;
        AluOp        alu_op;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } DecodeInfo;

    typedef struct packed {
        logic       stall_req;
        logic [3:0] flush_req;
    } PipeRequest;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

endpackage

// File: rtl/divider.sv
// Restoring divider, one quotient bit per cycle on operand magnitudes;
// signs are reapplied combinationally on the outputs.
module divider
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    input  logic        flush,
    input  logic        ack,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state, state_n;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs;
    logic        neg_q, neg_r;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh, rem_sub;

    assign a_neg   = is_signed & dividend[31];
    assign b_neg   = is_signed & divisor[31];
    assign a_mag   = a_neg ? -dividend : dividend;
    assign b_mag   = b_neg ? -divisor : divisor;
    assign rem_sh  = {rem, quo[31]};
    assign rem_sub = rem_sh - {1'b0, dvs};

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = DIV_IDLE;
        end else if (!hold) begin
            case (state)
                DIV_IDLE: if (start)      state_n = DIV_BUSY;
                DIV_BUSY: if (cnt == '0)  state_n = DIV_DONE;
                DIV_DONE: if (ack)        state_n = DIV_IDLE;
                default:                  state_n = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (!hold && !flush) begin
            if (state == DIV_IDLE && start) begin
                cnt   <= 5'd31;
                quo   <= a_mag;
                rem   <= '0;
                dvs   <= b_mag;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
            end else if (state == DIV_BUSY) begin
                cnt <= cnt - 5'd1;
                // Negative trial difference means the divisor did not fit: restore.
                if (!rem_sub[32]) begin
                    rem <= rem_sub[31:0];
                    quo <= {quo[30:0], 1'b1};
                end else begin
                    rem <= rem_sh[31:0];
                    quo <= {quo[30:0], 1'b0};
                end
            end
        end
    end

    assign busy      = (state == DIV_BUSY);
    assign done      = (state == DIV_DONE);
    assign quotient  = neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/execute.sv
// Execute stage: combinational ALU and multiplier, multi-cycle divider,
// and the registered result/store-data/info handoff to memory.
module execute
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  DecodeInfo   info,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] rs2_val,
    input  logic        stall_in,
    input  logic        flush_in,
    output PipeRequest  req,
    output logic [31:0] result,
    output logic [31:0] store_data,
    output DecodeInfo   info_ff
);

    logic [31:0]        alu_res, md_res, ex_res;
    logic signed [32:0] a33, b33;
    logic signed [63:0] prod;
    logic               is_div, div_zero, div_ovf, div_valid, stall_req;
    logic               div_busy, div_done;
    logic [31:0]        div_quo, div_rem;

    always_comb begin
        alu_res = '0;
        case (info.alu_op)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_SLL:    alu_res = op_a << op_b[4:0];
            ALU_SLT:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {31'b0, op_a < op_b};
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SRL:    alu_res = op_a >> op_b[4:0];
            ALU_SRA:    alu_res = $signed(op_a) >>> op_b[4:0];
            ALU_OR:     alu_res = op_a | op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_PASS_B: alu_res = op_b;
            default:    alu_res = '0;
        endcase
    end

    // 33x33 signed product; only the low 64 bits are ever needed.
    assign a33  = {(info.funct3[1:0] != 2'b11) & op_a[31], op_a};
    assign b33  = {(info.funct3[1:0] == 2'b01) & op_b[31], op_b};
    assign prod = 64'(a33) * 64'(b33);

    assign is_div    = info.muldiv & info.funct3[2];
    assign div_zero  = (op_b == '0);
    assign div_ovf   = ~info.funct3[0] & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
    assign div_valid = info.enable & is_div & ~div_zero & ~div_ovf;
    assign stall_req = div_valid & ~div_done;

    divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_valid & ~div_busy & ~div_done),
        .hold      (stall_in),
        .flush     (flush_in),
        .ack       (~stall_in),
        .is_signed (~info.funct3[0]),
        .dividend  (op_a),
        .divisor   (op_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        md_res = '0;
        if (!info.funct3[2])
            md_res = (info.funct3 == F3_MUL) ? prod[31:0] : prod[63:32];
        else if (div_zero)
            md_res = info.funct3[1] ? op_a : 32'hFFFF_FFFF;
        else if (div_ovf)
            md_res = info.funct3[1] ? 32'h0 : 32'h8000_0000;
        else if (div_done)
            md_res = info.funct3[1] ? div_rem : div_quo;
    end

    assign ex_res = info.muldiv ? md_res : alu_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result     <= '0;
            store_data <= '0;
            info_ff    <= '0;
        end else if (flush_in) begin
            info_ff <= '0;
        end else if (!stall_in) begin
            if (stall_req) begin
                info_ff <= '0;
            end else begin
                result     <= ex_res;
                store_data <= rs2_val;
                info_ff    <= info;
            end
        end
    end

    assign req.stall_req = stall_req;
    assign req.flush_req = 4'b0000;

endmodule

// File: tb/tb_execute.sv
// Random and directed stimulus for the execute stage against an arithmetic
// reference model built on 64-bit integer math.
module tb_execute;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    DecodeInfo   info;
    logic [31:0] op_a, op_b, rs2_val;
    logic        stall_in, flush_in;
    PipeRequest  req;
    logic [31:0] result, store_data;
    DecodeInfo   info_ff;

    int checks = 0;
    int errors = 0;

    execute dut (
        .clk(clk), .rst(rst), .info(info), .op_a(op_a), .op_b(op_b),
        .rs2_val(rs2_val), .stall_in(stall_in), .flush_in(flush_in),
        .req(req), .result(result), .store_data(store_data), .info_ff(info_ff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_calc(DecodeInfo i, logic [31:0] a, logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (!i.muldiv) begin
            case (i.alu_op)
                ALU_ADD:  return a + b;
                ALU_SUB:  return a - b;
                ALU_SLL:  return a << b[4:0];
                ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
                ALU_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
                ALU_XOR:  return a ^ b;
                ALU_SRL:  return a >> b[4:0];
                ALU_SRA:  return 32'(sa >>> b[4:0]);
                ALU_OR:   return a | b;
                ALU_AND:  return a & b;
                default:  return b;
            endcase
        end
        case (i.funct3)
            3'd0:    return 32'(sa * sb);
            3'd1:    return 32'((sa * sb) >>> 32);
            3'd2:    return 32'((sa * longint'(ub)) >>> 32);
            3'd3:    return 32'((ua * ub) >> 32);
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_stalls(DecodeInfo i, logic [31:0] a, logic [31:0] b);
        if (!(i.enable && i.muldiv && i.funct3[2]) || b == 0) return 0;
        if (!i.funct3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    function automatic DecodeInfo mk(logic en, logic md, logic [2:0] f3, AluOp op);
        DecodeInfo d;
        d.enable     = en;
        d.pc         = $urandom & 32'hFFFF_FFFC;
        d.funct3     = f3;
        d.muldiv     = md;
        d.alu_op     = op;
        d.mem_read   = 1'($urandom);
        d.mem_write  = 1'($urandom);
        d.mem_to_reg = 1'($urandom);
        return d;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_op(input string tag, input DecodeInfo i, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] s);
        int n = 0;
        info = i; op_a = a; op_b = b; rs2_val = s;
        #1;
        while (req.stall_req && n < 60) begin
            n++;
            @(negedge clk); #1;
            if (n == 1) chk({tag, "_bubble"}, info_ff, 0);
        end
        chk({tag, "_stalls"}, n, ref_stalls(i, a, b));
        @(negedge clk); #1;
        chk({tag, "_result"}, result, ref_calc(i, a, b));
        chk({tag, "_store"}, store_data, s);
        chk({tag, "_info"}, info_ff, i);
        chk({tag, "_flushreq"}, req.flush_req, 0);
    endtask

    initial begin
        int n;
        DecodeInfo d;
        rst = 1'b1; info = '0; op_a = '0; op_b = '0; rs2_val = '0;
        stall_in = 1'b0; flush_in = 1'b0;
        #12;
        chk("reset_result", result, 0);
        chk("reset_store", store_data, 0);
        chk("reset_info", info_ff, 0);
        chk("reset_stall", req.stall_req, 0);
        @(negedge clk); rst = 1'b0;

        run_op("add", mk(1, 0, 3'd0, ALU_ADD), 32'd5, 32'd7, 32'h1234);
        run_op("div", mk(1, 1, F3_DIV, ALU_ADD), 32'hFFFF_FFF9, 32'd2, 32'h55);
        run_op("rem", mk(1, 1, F3_REM, ALU_ADD), 32'hFFFF_FFF9, 32'd2, 32'h66);
        run_op("divu0", mk(1, 1, F3_DIVU, ALU_ADD), 32'd100, 32'd0, 32'h77);
        run_op("removf", mk(1, 1, F3_REM, ALU_ADD), 32'h8000_0000, 32'hFFFF_FFFF, 32'h88);
        run_op("divovf", mk(1, 1, F3_DIV, ALU_ADD), 32'h8000_0000, 32'hFFFF_FFFF, 32'h99);
        run_op("mulh", mk(1, 1, F3_MULH, ALU_ADD), 32'h8000_0000, 32'h8000_0000, 32'h1);
        run_op("mulhu", mk(1, 1, F3_MULHU, ALU_ADD), 32'hFFFF_FFFF, 32'd2, 32'h2);
        run_op("div_en0", mk(0, 1, F3_DIV, ALU_ADD), 32'hFFFF_FFFF, 32'h8000_0000, 32'h3);

        // Flush at BUSY cycle 10, then a fresh divide must take the full latency.
        info = mk(1, 1, F3_DIVU, ALU_ADD); op_a = 32'd1000; op_b = 32'd7;
        repeat (11) @(negedge clk);
        flush_in = 1'b1; info = '0;
        @(negedge clk); #1;
        flush_in = 1'b0;
        chk("flush_stall", req.stall_req, 0);
        chk("flush_info", info_ff, 0);
        run_op("after_flush", mk(1, 1, F3_DIVU, ALU_ADD), 32'd100, 32'd7, 32'h4);

        // Asynchronous reset in BUSY cycle 5 clears outputs before any edge.
        run_op("pre_rst", mk(1, 0, 3'd0, ALU_ADD), 32'd5, 32'd7, 32'hABCD);
        info = mk(1, 1, F3_DIV, ALU_ADD); op_a = 32'hFFFF_FF9C; op_b = 32'd3;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_result", result, 0);
        chk("arst_store", store_data, 0);
        chk("arst_info", info_ff, 0);
        info = '0;
        @(negedge clk); rst = 1'b0;
        run_op("after_rst", mk(1, 1, F3_DIV, ALU_ADD), 32'hFFFF_FF9C, 32'd3, 32'h5);

        // stall_in holds the output registers.
        info = mk(1, 0, 3'd0, ALU_ADD); op_a = 32'd3; op_b = 32'd4; rs2_val = 32'h6;
        stall_in = 1'b1;
        @(negedge clk); #1;
        chk("hold_result", result, ref_calc(mk(1, 1, F3_DIV, ALU_ADD), 32'hFFFF_FF9C, 32'd3));
        stall_in = 1'b0;
        @(negedge clk); #1;
        chk("hold_release", result, 32'd7);

        // stall_in during BUSY freezes the divider for five cycles.
        d = mk(1, 1, F3_DIVU, ALU_ADD);
        info = d; op_a = 32'd50; op_b = 32'd5;
        #1;
        n = 0;
        while (req.stall_req && n < 80) begin
            n++;
            @(negedge clk);
            stall_in = (n >= 3 && n < 8);
            #1;
        end
        stall_in = 1'b0;
        chk("frozen_stalls", n, 38);
        @(negedge clk); #1;
        chk("frozen_result", result, 32'd10);

        for (int k = 0; k < 80; k++) begin
            logic md;
            logic [2:0] f3;
            logic en;
            md = 1'($urandom);
            f3 = 3'($urandom);
            en = ($urandom_range(0, 7) != 0) || (md && f3[2]);
            run_op("rand", mk(en, md, f3, AluOp'($urandom_range(0, 10))), pick(), pick(), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have port clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port info  in  DecodeInfo  instruction from decode; fields used: enable, pc, funct3, muldiv, alu_op, mem_read, mem_write, mem_to_reg.
REQ-004 SHALL have port op_a  in  32  forwarded rs1 value.
REQ-005 SHALL have port op_b  in  32  forwarded rs2 or immediate, already muxed by decode.
REQ-006 SHALL have port rs2_val  in  32  forwarded rs2, used as store data.
REQ-007 SHALL have port stall_in  in  1  downstream stall (memory stage); holds this stage.
REQ-008 SHALL have port flush_in  in  1  squash the in-flight instruction.
REQ-009 SHALL have port req  out  PipeRequest  stall_req and flush_req (4 bit) to the hazard unit.
REQ-010 SHALL have port result  out  32  registered ALU/M result; memory stage uses it as address or writeback value.
REQ-011 SHALL have port store_data  out  32  registered rs2_val.
REQ-012 SHALL have port info_ff  out  DecodeInfo  registered info accompanying result.

Function
REQ-013 SHALL compute ALU ops combinationally per info.alu_op: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B; shift amount op_b[4:0].
REQ-014 SHALL, when info.muldiv=1, select the op by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-015 SHALL compute MUL* in one cycle as a 33x33 signed product of sign/zero-extended operands; MUL returns bits [31:0], MULH* return bits [63:32].
REQ-016 SHALL implement DIV/REM with a restoring divider, one quotient bit per cycle, using FSM states IDLE, BUSY, DONE.
REQ-017 Transitions: IDLE->BUSY on a valid div op (enable=1, not a special case); counter loaded with 31. BUSY decrements the counter and goes to DONE after the counter=0 cycle. DONE->IDLE when the result is captured.
REQ-018 Divider operates on magnitudes for signed ops; it negates the quotient if the operand signs differ and negates the remainder to match the dividend sign.
REQ-019 stall_req SHALL be 1 while a valid div op is present and state!=DONE: 33 cycles (issue cycle + 32 BUSY), then 0 in DONE.
REQ-020 Divide by zero: quotient 0xFFFFFFFF, remainder = op_a; resolves in one cycle with no stall.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0; resolves in one cycle with no stall.
REQ-022 Output registers SHALL capture result, store_data and info_ff on each edge where stall_in=0 and stall_req=0.
REQ-023 SHALL load info_ff with 0 (bubble) when stall_req=1 and stall_in=0.
REQ-024 stall_in=1 SHALL hold the output registers and the divider state/counter unchanged.
REQ-025 flush_in=1 SHALL force the FSM to IDLE and info_ff to 0 at the next edge, with priority over stall_in.
REQ-026 req.flush_req SHALL be constant 4'b0000; branch redirect is owned elsewhere.
REQ-027 An instruction with enable=0 SHALL never start the divider or raise stall_req.

Reset
REQ-028 rst SHALL clear the FSM to IDLE, the counter, quotient, remainder and divisor registers, result, store_data and info_ff to 0.
REQ-029 rst asserted during BUSY SHALL abandon the division; after release no stale result appears.

Structure
REQ-030 The AluOp enum, the muldiv funct3 constants and the muldiv bit added to DecodeInfo SHALL live in the shared common package.
REQ-031 The divider SHALL be a sub-module named divider, with handshake start/busy/done, operands, signed flag and outputs quotient/remainder.

Verification
REQ-032 ADD op_a=5, op_b=7 -> result=12 one cycle later; stall_req never asserted.
REQ-033 DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> stall_req high 33 cycles, then result=0xFFFFFFFD (-3); REM of the same operands -> 0xFFFFFFFF.
REQ-034 DIVU op_a=100, op_b=0 -> result=0xFFFFFFFF with no stall; REM op_a=0x80000000, op_b=0xFFFFFFFF -> result 0.
REQ-035 MULH op_a=0x80000000, op_b=0x80000000 -> result=0x40000000; MULHU op_a=0xFFFFFFFF, op_b=2 -> result 1.
REQ-036 flush_in pulsed at BUSY cycle 10 -> FSM goes to IDLE, info_ff=0 and stall_req drops; async rst at BUSY cycle 5 -> all outputs 0 immediately.
